// File: rtl/core_seq_ctrl.sv
// core_seq_ctrl: multi-cycle FETCH/DECODE/REGREAD/ALU/WB sequencer that owns the PC and gates unit enables.
// Latency: 5 cycles per instruction with memory ready on the first FETCH cycle, plus 1 cycle per FETCH wait cycle.
// Backpressure: stalls in FETCH while I_mem_ready is low (no timeout); optional retire counter under CORE_SEQ_RETIRE_CNT_EN.
module core_seq_ctrl #(
    parameter int          PC_W     = 16,
    parameter int unsigned PC_RESET = 0,
    parameter int unsigned PC_STEP  = 1
) (
    input  logic            I_clk,
    input  logic            I_rst_n,
    input  logic            I_run,
    input  logic            I_mem_ready,
    input  logic            I_regwe,
    input  logic            I_halt,
    input  logic            I_branch,
    input  logic [PC_W-1:0] I_target,
    output logic [PC_W-1:0] o_pc,
    output logic            o_mem_req,
    output logic            o_en_dec,
    output logic            o_en_reg,
    output logic            o_en_alu,
    output logic            o_regwe,
    output logic [2:0]      o_state,
    output logic            o_halted
`ifdef CORE_SEQ_RETIRE_CNT_EN
    ,
    output logic [31:0]     o_retired
`endif
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_REGREAD = 3'd3,
        S_ALU     = 3'd4,
        S_WB      = 3'd5,
        S_HALT    = 3'd6
    } state_t;

    localparam logic [PC_W-1:0] PC_RST_V  = PC_W'(PC_RESET);
    localparam logic [PC_W-1:0] PC_STEP_V = PC_W'(PC_STEP);

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            br_q, br_d;
    logic [PC_W-1:0] tgt_q, tgt_d;

    // State, PC and captured branch decision; reset aborts any in-flight instruction.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= PC_RST_V;
            br_q    <= 1'b0;
            tgt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            br_q    <= br_d;
            tgt_q   <= tgt_d;
        end
    end

    // Next-state, PC update and one-hot enable decode from the state register.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        br_d      = br_q;
        tgt_d     = tgt_q;
        o_mem_req = 1'b0;
        o_en_dec  = 1'b0;
        o_en_reg  = 1'b0;
        o_en_alu  = 1'b0;
        o_regwe   = 1'b0;
        o_halted  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (I_run) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                // I_run is deliberately ignored here: once a fetch is issued it completes.
                o_mem_req = 1'b1;
                if (I_mem_ready) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                o_en_dec = 1'b1;
                state_d  = S_REGREAD;
            end
            S_REGREAD: begin
                // Halt is checked before the ALU ever sees the instruction, so a
                // simultaneous branch can never move the PC of a halting instruction.
                o_en_reg = 1'b1;
                state_d  = I_halt ? S_HALT : S_ALU;
            end
            S_ALU: begin
                o_en_alu = 1'b1;
                br_d     = I_branch;
                tgt_d    = I_target;
                state_d  = S_WB;
            end
            S_WB: begin
                o_regwe = I_regwe;
                pc_d    = br_q ? tgt_q : (pc_q + PC_STEP_V);
                state_d = I_run ? S_FETCH : S_IDLE;
            end
            S_HALT: begin
                o_halted = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign o_pc    = pc_q;
    assign o_state = state_q;

`ifdef CORE_SEQ_RETIRE_CNT_EN
    logic [31:0] retired_q, retired_d;

    // Retired-instruction count: bumps on each WB edge; halted instructions never reach WB.
    always_comb begin
        retired_d = retired_q;
        if (state_q == S_WB) begin
            retired_d = retired_q + 32'd1;
        end
    end

    // Retire counter register, wrapping naturally at 32 bits.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            retired_q <= '0;
        end else begin
            retired_q <= retired_d;
        end
    end

    assign o_retired = retired_q;
`endif

endmodule

// File: tb/tb_core_seq_ctrl.sv
module tb_core_seq_ctrl;

    logic        I_clk;
    logic        I_rst_n;
    logic        I_run;
    logic        I_mem_ready;
    logic        I_regwe;
    logic        I_halt;
    logic        I_branch;
    logic [15:0] I_target;
    logic [15:0] o_pc;
    logic        o_mem_req;
    logic        o_en_dec;
    logic        o_en_reg;
    logic        o_en_alu;
    logic        o_regwe;
    logic [2:0]  o_state;
    logic        o_halted;
`ifdef CORE_SEQ_RETIRE_CNT_EN
    logic [31:0] o_retired;
`endif

    core_seq_ctrl #(
        .PC_W     (16),
        .PC_RESET (32'h0010),
        .PC_STEP  (1)
    ) dut (
        .I_clk       (I_clk),
        .I_rst_n     (I_rst_n),
        .I_run       (I_run),
        .I_mem_ready (I_mem_ready),
        .I_regwe     (I_regwe),
        .I_halt      (I_halt),
        .I_branch    (I_branch),
        .I_target    (I_target),
        .o_pc        (o_pc),
        .o_mem_req   (o_mem_req),
        .o_en_dec    (o_en_dec),
        .o_en_reg    (o_en_reg),
        .o_en_alu    (o_en_alu),
        .o_regwe     (o_regwe),
        .o_state     (o_state),
        .o_halted    (o_halted)
`ifdef CORE_SEQ_RETIRE_CNT_EN
        ,
        .o_retired   (o_retired)
`endif
    );

    initial I_clk = 1'b0;
    always #5 I_clk = ~I_clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] model_pc;
    int unsigned model_ret;
    logic [15:0] exp_q[$];
    logic        wb_seen = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_en(input string tag, input logic [4:0] exp);
        chk(tag, {27'd0, o_mem_req, o_en_dec, o_en_reg, o_en_alu, o_regwe}, {27'd0, exp});
    endtask

    // Scoreboard: the cycle after a WB, the new PC must match the queued expectation.
    always @(negedge I_clk) begin
        if (wb_seen) begin
            if (exp_q.size() == 0) begin
                chk("wb_pc_queue_empty", {16'd0, o_pc}, 32'hDEAD);
            end else begin
                chk("wb_pc", {16'd0, o_pc}, {16'd0, exp_q.pop_front()});
            end
        end
        wb_seen = (o_state == 3'd5) && I_rst_n;
    end

    // One full instruction, called at a negedge where the next edge enters FETCH.
    // Branch noise is driven in every non-ALU cycle to show it is ignored there.
    task automatic instr(input logic br, input logic [15:0] tgt, input int wt,
                         input logic rwe, input logic drop_run);
        logic [15:0] old_pc;
        int          req_cnt;
        old_pc   = model_pc;
        req_cnt  = 0;
        I_run    = 1'b1;
        I_halt   = 1'b0;
        I_regwe  = rwe;
        I_branch = 1'b1;
        I_target = 16'h1234;
        for (int i = 0; i <= wt; i++) begin
            @(negedge I_clk);
            chk("fetch_state", {29'd0, o_state}, 32'd1);
            chk_en("fetch_en", 5'b10000);
            if (o_mem_req) req_cnt++;
            I_mem_ready = (i == wt);
        end
        chk("fetch_req_cycles", req_cnt, wt + 1);
        @(negedge I_clk);
        chk("decode_state", {29'd0, o_state}, 32'd2);
        chk_en("decode_en", 5'b01000);
        I_mem_ready = 1'b0;
        if (drop_run) I_run = 1'b0;
        @(negedge I_clk);
        chk("regread_state", {29'd0, o_state}, 32'd3);
        chk_en("regread_en", 5'b00100);
        @(negedge I_clk);
        chk("alu_state", {29'd0, o_state}, 32'd4);
        chk_en("alu_en", 5'b00010);
        I_branch = br;
        I_target = tgt;
        model_pc = br ? tgt : model_pc + 16'd1;
        exp_q.push_back(model_pc);
        model_ret++;
        @(negedge I_clk);
        chk("wb_state", {29'd0, o_state}, 32'd5);
        chk_en("wb_en", {4'b0000, rwe});
        chk("wb_pc_old", {16'd0, o_pc}, {16'd0, old_pc});
        I_branch = 1'b1;
        I_target = 16'h2222;
    endtask

    initial begin
        I_rst_n     = 1'b0;
        I_run       = 1'b0;
        I_mem_ready = 1'b0;
        I_regwe     = 1'b1;
        I_halt      = 1'b0;
        I_branch    = 1'b0;
        I_target    = 16'h0000;
        model_pc    = 16'h0010;
        model_ret   = 0;

        // Reset state
        @(negedge I_clk);
        @(negedge I_clk);
        chk("rst_state", {29'd0, o_state}, 32'd0);
        chk("rst_pc", {16'd0, o_pc}, 32'h0010);
        chk_en("rst_en", 5'b00000);
        chk("rst_halted", {31'd0, o_halted}, 32'd0);
`ifdef CORE_SEQ_RETIRE_CNT_EN
        chk("rst_retired", o_retired, 32'd0);
`endif

        // Sequential instructions, then a 3-cycle fetch wait with a taken branch
        I_rst_n = 1'b1;
        instr(1'b0, 16'h0000, 0, 1'b1, 1'b0);
        instr(1'b0, 16'h0000, 0, 1'b0, 1'b0);
        instr(1'b1, 16'h0040, 3, 1'b1, 1'b0);

        // PC wrap from 0xFFFF
        instr(1'b1, 16'hFFFF, 0, 1'b0, 1'b0);
        instr(1'b0, 16'h0000, 0, 1'b1, 1'b0);

        // Run dropped mid-instruction: completes, then idles
        instr(1'b0, 16'h0000, 0, 1'b1, 1'b1);
        @(negedge I_clk);
        chk("run_drop_idle", {29'd0, o_state}, 32'd0);
        @(negedge I_clk);
        chk("run_drop_stay_idle", {29'd0, o_state}, 32'd0);
        instr(1'b0, 16'h0000, 1, 1'b1, 1'b0);

        // Halt in REGREAD with a branch also requested
        I_branch    = 1'b1;
        I_target    = 16'h0777;
        @(negedge I_clk);
        chk("halt_fetch", {29'd0, o_state}, 32'd1);
        I_mem_ready = 1'b1;
        @(negedge I_clk);
        chk("halt_decode", {29'd0, o_state}, 32'd2);
        I_mem_ready = 1'b0;
        @(negedge I_clk);
        chk("halt_regread", {29'd0, o_state}, 32'd3);
        I_halt = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge I_clk);
            I_halt      = 1'b0;
            I_mem_ready = 1'b1;
            chk("halt_state", {29'd0, o_state}, 32'd6);
            chk("halt_flag", {31'd0, o_halted}, 32'd1);
            chk_en("halt_en", 5'b00000);
            chk("halt_pc", {16'd0, o_pc}, {16'd0, model_pc});
        end
`ifdef CORE_SEQ_RETIRE_CNT_EN
        chk("halt_retired", o_retired, model_ret);
`endif
        I_rst_n = 1'b0;
        #1;
        chk("halt_rst_state", {29'd0, o_state}, 32'd0);
        chk("halt_rst_pc", {16'd0, o_pc}, 32'h0010);
        chk("halt_rst_flag", {31'd0, o_halted}, 32'd0);
        model_pc  = 16'h0010;
        model_ret = 0;
        @(negedge I_clk);
        I_rst_n     = 1'b1;
        I_mem_ready = 1'b1;

        // Reset asserted during ALU: abort, PC not advanced
        @(negedge I_clk);
        chk("abort_fetch", {29'd0, o_state}, 32'd1);
        @(negedge I_clk);
        @(negedge I_clk);
        @(negedge I_clk);
        chk("abort_alu", {29'd0, o_state}, 32'd4);
        I_branch = 1'b1;
        I_target = 16'h0040;
        #2;
        I_rst_n = 1'b0;
        #1;
        chk("abort_state", {29'd0, o_state}, 32'd0);
        chk("abort_pc", {16'd0, o_pc}, 32'h0010);
        chk_en("abort_en", 5'b00000);
`ifdef CORE_SEQ_RETIRE_CNT_EN
        chk("abort_retired", o_retired, 32'd0);
`endif
        @(negedge I_clk);
        chk("abort_hold_pc", {16'd0, o_pc}, 32'h0010);
        I_rst_n = 1'b1;

        // Clean instruction after abort
        instr(1'b0, 16'h0000, 0, 1'b1, 1'b1);
        @(negedge I_clk);
        chk("final_idle", {29'd0, o_state}, 32'd0);
`ifdef CORE_SEQ_RETIRE_CNT_EN
        chk("final_retired", o_retired, model_ret);
`endif
        @(negedge I_clk);
        chk("scoreboard_drained", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/core_seq_ctrl.md
# core_seq_ctrl

Multi-cycle instruction sequencer for the 16-bit core. It walks each instruction through FETCH, DECODE, REGREAD, ALU and WB, owns the program counter and handshakes with instruction memory. It generates the one-cycle enables for the instruction decoder (`inst_dec`), the register file and the ALU, and gates the decoder's register write-enable so it only reaches the register file during writeback.

## Interface
Parameters:
- `PC_W`, 16, program-counter width.
- `PC_RESET`, 0, PC value loaded on reset.
- `PC_STEP`, 1, PC increment per non-branch instruction (word addressed).

Ports:
- `I_clk` in 1: single clock, rising edge.
- `I_rst_n` in 1: reset, asynchronous, active-low.
- `I_run` in 1: level; the sequencer starts or continues instructions only while high.
- `I_mem_ready` in 1: instruction memory has `I_inst` valid for the current request.
- `I_regwe` in 1: decoder `o_regwe`.
- `I_halt` in 1: halt opcode flag from the decoder; sampled only in REGREAD.
- `I_branch` in 1: branch-taken flag from the ALU; sampled only in ALU.
- `I_target` in PC_W: branch target; sampled only in ALU.
- `o_pc` out PC_W: current instruction address.
- `o_mem_req` out 1: instruction fetch request.
- `o_en_dec` out 1: decoder `I_en`.
- `o_en_reg` out 1: register-file read enable.
- `o_en_alu` out 1: ALU enable.
- `o_regwe` out 1: gated register write-enable.
- `o_state` out 3: state encoding, for debug.
- `o_halted` out 1: core halted.

## Operation
- States and `o_state` codes:
  - IDLE = 0
  - FETCH = 1
  - DECODE = 2
  - REGREAD = 3
  - ALU = 4
  - WB = 5
  - HALT = 6
  - Codes 7 and above are illegal and go to IDLE on the next edge.
- IDLE: if `I_run` = 1, go to FETCH; otherwise stay in IDLE.
- FETCH:
  - `o_mem_req` = 1.
  - If `I_mem_ready` = 1, go to DECODE; otherwise stay in FETCH. The wait is unbounded.
  - `I_run` is ignored while in FETCH.
- DECODE: `o_en_dec` = 1 for exactly one cycle; go to REGREAD.
- REGREAD:
  - `o_en_reg` = 1.
  - If `I_halt` = 1, go to HALT; otherwise go to ALU.
- ALU:
  - `o_en_alu` = 1.
  - Capture `I_branch` into internal `br_q` and `I_target` into `tgt_q`.
  - Go to WB.
- WB:
  - `o_regwe` = `I_regwe`.
  - At the WB edge, `o_pc` is updated: `tgt_q` if `br_q` = 1, else `o_pc + PC_STEP`, truncated to PC_W bits (wraps from 2^PC_W-1 to 0).
  - If `I_run` = 1, go to FETCH; otherwise go to IDLE.
- HALT:
  - `o_halted` = 1 and no enables are asserted.
  - PC is frozen at the halting instruction's address.
  - Exit only by reset.
- Enables:
  - `o_mem_req`, `o_en_dec`, `o_en_reg`, `o_en_alu` and `o_regwe` are decoded combinationally from the state register.
  - At most one of them is high in any cycle.
- `o_regwe` is 0 in every state other than WB, regardless of `I_regwe`.

## Timing
- Reset values:
  - State = IDLE.
  - `o_pc` = PC_RESET.
  - `br_q` = 0, `tgt_q` = 0.
  - All enables, `o_regwe` and `o_halted` = 0.
  - `o_state` = 0.
- Asserting `I_rst_n` low mid-instruction aborts immediately and asynchronously. Any pending WB is discarded; the PC is not updated.
- Reset deassertion is synchronised externally. The first IDLE→FETCH transition can occur on the first edge after `I_rst_n` goes high.
- Latency:
  - With `I_mem_ready` high in the first FETCH cycle, one instruction takes 5 cycles (FETCH..WB).
  - Back-to-back instructions with `I_run` held high issue every 5 cycles.
  - Each cycle `I_mem_ready` is low in FETCH adds one cycle.
- Decoder outputs are registered on the DECODE edge and are therefore valid in REGREAD, ALU and WB.
- `I_branch` and `I_target` matter only on the ALU-cycle edge; changes in other cycles have no effect.
- `I_halt` and `I_branch` active in the same instruction: halt wins, because `I_branch` is never sampled.
- `I_run` falling mid-instruction: the instruction completes through WB, then the sequencer goes to IDLE.

## Configuration
- `CORE_SEQ_RETIRE_CNT_EN`:
  - Defined: adds output `o_retired` (32 bits, reset 0). It increments by 1 on every WB edge and wraps from 0xFFFFFFFF to 0. A halted instruction is not counted.
  - Undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Reset with `PC_RESET` = 0x0010, then `I_run` = 1 and `I_mem_ready` = 1 constantly → `o_state` sequence 1,2,3,4,5,1… and `o_pc` = 0x0011 after the first WB edge, 0x0012 after the second.
- `I_mem_ready` held low for 3 FETCH cycles → `o_mem_req` high for 4 cycles; instruction completes in 8 cycles; no other enable is asserted during the wait.
- `I_branch` = 1 with `I_target` = 0x0040 in the ALU cycle → `o_pc` = 0x0040 after WB. `I_branch` = 1 in any other state → no effect.
- `I_inst` = 16'b1110000000000100 with decoder `o_regwe` = 1 → `o_regwe` high only in the WB cycle, exactly 1 cycle per instruction.
- `I_halt` = 1 in REGREAD → `o_halted` = 1, `o_state` = 6, PC unchanged, no enables. `I_rst_n` pulsed low → IDLE and PC = PC_RESET.
- `o_pc` = 0xFFFF with no branch → 0x0000 after WB. Reset asserted in ALU → immediate IDLE; PC not updated; with the macro defined, `o_retired` = 0.
